// File: rtl/axi_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// axi_wr_burst_ctrl
//
// Purpose:
//   AXI write-channel slave that turns one AXI write burst into a sequence of
//   single-beat RAM write requests. The controller handles one burst at a time.
//   A RAM target (region) is chosen by AWREGION. Each beat waits for that
//   region's write-complete pulse before the next beat is accepted. Bursts that
//   are malformed or address a missing region are still fully drained. They
//   issue no RAM writes and end with an error response.
//
// Optional feature:
//   AXI_WR_WLAST_CHK_EN : when defined, WLAST is compared with the beat count.
//                         A mismatch turns the response into SLVERR, unless it
//                         is already DECERR. When undefined, WLAST is ignored.
//
// Ports:
//   clk, rst_n             single rising-edge clock, asynchronous active-low reset
//   AW* (ID/ADDR/LEN/SIZE/BURST/REGION/VALID/READY)
//                          write address channel
//   W*  (DATA/STRB/LAST/VALID/READY)
//                          write data channel
//   B*  (ID/RESP/VALID/READY)
//                          write response channel
//   ram_wr_vld/sel/addr/data/strb
//                          one-cycle registered RAM write request, one-hot region select
//   ram_wr_done            per-region write-complete pulse from the RAMs
//   busy                   high whenever the controller is not idle
// -----------------------------------------------------------------------------
module axi_wr_burst_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 11,
  parameter int ID_W       = 8,
  parameter int NUM_REGION = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [ID_W-1:0]       AWID,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic [3:0]            AWREGION,
  input  logic                  AWVALID,
  output logic                  AWREADY,

  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,

  output logic [ID_W-1:0]       BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,

  output logic                  ram_wr_vld,
  output logic [NUM_REGION-1:0] ram_wr_sel,
  output logic [ADDR_W-1:0]     ram_wr_addr,
  output logic [DATA_W-1:0]     ram_wr_data,
  output logic [DATA_W/8-1:0]   ram_wr_strb,
  input  logic [NUM_REGION-1:0] ram_wr_done,

  output logic                  busy
);

  localparam int              STRB_W      = DATA_W / 8;
  localparam logic [2:0]      SIZE_MAX    = 3'($clog2(STRB_W));
  localparam logic [4:0]      REGION_CNT  = 5'(NUM_REGION);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Fields captured from the address phase.
  logic [ID_W-1:0]       cap_id;
  logic [ADDR_W-1:0]     cap_addr;
  logic [7:0]            cap_len;
  logic [2:0]            cap_size;
  logic [1:0]            cap_burst;
  logic [NUM_REGION-1:0] cap_mask;
  logic                  cap_suppress;

  logic [7:0]            beat;
  logic [1:0]            resp_q;
  logic                  awready_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  done_hit;
  logic                  last_beat;
  logic                  beat_done;
  logic                  aw_decerr;
  logic                  aw_slverr;
  logic                  wrap_len_ok;
  logic [NUM_REGION-1:0] aw_mask;
  logic [ADDR_W-1:0]     step;
  logic [ADDR_W-1:0]     wrap_mask;
  logic [ADDR_W-1:0]     addr_sum;
  logic [ADDR_W-1:0]     addr_nxt;

  assign aw_hs     = AWVALID && awready_q;
  assign w_hs      = (state == DATA) && WVALID;
  assign last_beat = (beat == cap_len);

  // A region index at or beyond NUM_REGION shifts the one out of the mask.
  // That leaves an all-zero mask, so a decode-error burst can never see a done pulse.
  assign aw_mask  = {{(NUM_REGION-1){1'b0}}, 1'b1} << AWREGION;
  assign done_hit = |(ram_wr_done & cap_mask);

  // Suppressed bursts never issue a RAM write, so WAIT has nothing to wait for.
  assign beat_done = (state == WAIT) && (cap_suppress || done_hit);

  // Classify the burst while it is still on the AW channel.
  // The response and the write-suppress flag are then known before the first beat.
  always_comb begin
    wrap_len_ok = (AWLEN == 8'd1) || (AWLEN == 8'd3) ||
                  (AWLEN == 8'd7) || (AWLEN == 8'd15);
    aw_decerr   = ({1'b0, AWREGION} >= REGION_CNT);
    aw_slverr   = (AWBURST == 2'b11) ||
                  ((AWBURST == BURST_WRAP) && !wrap_len_ok) ||
                  (AWSIZE > SIZE_MAX);
  end

  // Next beat address. Only legal wrap lengths reach a RAM write.
  // For those, (len+1)*step is a power of two, so the wrap block is a plain bit mask.
  always_comb begin
    step      = ADDR_W'(1) << cap_size;
    wrap_mask = ((ADDR_W'(cap_len) + ADDR_W'(1)) << cap_size) - ADDR_W'(1);
    addr_sum  = cap_addr + step;
    case (cap_burst)
      BURST_FIXED: addr_nxt = cap_addr;
      BURST_INCR:  addr_nxt = addr_sum;
      BURST_WRAP:  addr_nxt = (cap_addr & ~wrap_mask) | (addr_sum & wrap_mask);
      default:     addr_nxt = cap_addr;
    endcase
  end

`ifdef AXI_WR_WLAST_CHK_EN
  logic wlast_bad;
  assign wlast_bad = (WLAST != last_beat);
`else
  logic unused_wlast;
  assign unused_wlast = WLAST;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (aw_hs)     state_nxt = DATA;
      DATA: if (w_hs)      state_nxt = WAIT;
      WAIT: if (beat_done) state_nxt = last_beat ? RESP : DATA;
      RESP: if (BREADY)    state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping and the registered RAM request.
  // AWREADY is registered from the next state. It is therefore low throughout reset,
  // rises on the first clock after release, and drops on the edge that accepts an address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q    <= 1'b0;
      cap_id       <= '0;
      cap_addr     <= '0;
      cap_len      <= '0;
      cap_size     <= '0;
      cap_burst    <= '0;
      cap_mask     <= '0;
      cap_suppress <= 1'b0;
      beat         <= '0;
      resp_q       <= RESP_OKAY;
      ram_wr_vld   <= 1'b0;
      ram_wr_sel   <= '0;
      ram_wr_addr  <= '0;
      ram_wr_data  <= '0;
      ram_wr_strb  <= '0;
    end else begin
      awready_q  <= (state_nxt == IDLE);
      ram_wr_vld <= 1'b0;
      ram_wr_sel <= '0;

      if (aw_hs) begin
        cap_id       <= AWID;
        cap_addr     <= AWADDR;
        cap_len      <= AWLEN;
        cap_size     <= AWSIZE;
        cap_burst    <= AWBURST;
        cap_mask     <= aw_mask;
        cap_suppress <= aw_decerr || aw_slverr;
        beat         <= '0;
        resp_q       <= aw_decerr ? RESP_DECERR :
                        aw_slverr ? RESP_SLVERR : RESP_OKAY;
      end

      if (w_hs) begin
        if (!cap_suppress) begin
          ram_wr_vld  <= 1'b1;
          ram_wr_sel  <= cap_mask;
          ram_wr_addr <= cap_addr;
          ram_wr_data <= WDATA;
          ram_wr_strb <= WSTRB;
        end
`ifdef AXI_WR_WLAST_CHK_EN
        if (wlast_bad && (resp_q != RESP_DECERR)) begin
          resp_q <= RESP_SLVERR;
        end
`endif
      end

      if (beat_done && !last_beat) begin
        cap_addr <= addr_nxt;
        beat     <= beat + 8'd1;
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = (state == DATA);
  assign BVALID  = (state == RESP);
  assign BID     = cap_id;
  assign BRESP   = resp_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_axi_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_burst_ctrl
//
// Self-checking bench for axi_wr_burst_ctrl (DATA_W=32, ADDR_W=11, ID_W=8,
// NUM_REGION=4). The stimulus side predicts every RAM write and every response
// from the burst rules. It queues those predictions. A monitor pops and
// compares them whenever the DUT presents a RAM write or a response
// handshake. A RAM model answers each write with a done pulse after a random
// delay. Random traffic is driven on the done bits of unselected regions.
// -----------------------------------------------------------------------------
module tb_axi_wr_burst_ctrl;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 11;
  localparam int ID_W       = 8;
  localparam int NUM_REGION = 4;
  localparam int STRB_W     = DATA_W / 8;

  logic                  clk;
  logic                  rst_n;
  logic [ID_W-1:0]       AWID;
  logic [ADDR_W-1:0]     AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic [3:0]            AWREGION;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [STRB_W-1:0]     WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  logic [ID_W-1:0]       BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic                  ram_wr_vld;
  logic [NUM_REGION-1:0] ram_wr_sel;
  logic [ADDR_W-1:0]     ram_wr_addr;
  logic [DATA_W-1:0]     ram_wr_data;
  logic [STRB_W-1:0]     ram_wr_strb;
  logic [NUM_REGION-1:0] ram_wr_done;
  logic                  busy;

  axi_wr_burst_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .NUM_REGION(NUM_REGION)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWREGION(AWREGION), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ram_wr_vld(ram_wr_vld), .ram_wr_sel(ram_wr_sel), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_wr_strb(ram_wr_strb), .ram_wr_done(ram_wr_done),
    .busy(busy)
  );

  typedef struct {
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data;
    logic [STRB_W-1:0]     strb;
    logic [NUM_REGION-1:0] sel;
  } wr_t;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } rsp_t;

  wr_t  wq[$];
  rsp_t rq[$];
  wr_t  mon_w;
  rsp_t mon_r;

  int checks   = 0;
  int failures = 0;

  bit mon_en      = 1'b1;
  bit ram_en      = 1'b1;
  bit bready_hold = 1'b0;

  logic [NUM_REGION-1:0] cur_mask = '0;
  logic [NUM_REGION-1:0] done_sel = '0;
  logic [NUM_REGION-1:0] noise    = '0;

  // Done bits of regions other than the active one carry random traffic.
  assign ram_wr_done = done_sel | (noise & ~cur_mask);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and keep the counts.
  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=handshake", name);
  endtask

  task automatic step_drive();
    @(posedge clk);
    #1;
  endtask

  // Behavioural address model: beat i of a burst, computed from the start address.
  function automatic logic [ADDR_W-1:0] model_addr(input int start, input int len,
                                                   input int size, input int burst,
                                                   input int i);
    int stp;
    int blk;
    int base;
    int a;
    stp = 1 << size;
    case (burst)
      1: a = start + i * stp;
      2: begin
        blk  = (len + 1) * stp;
        base = (start / blk) * blk;
        a    = base + ((start - base) + i * stp) % blk;
      end
      default: a = start;
    endcase
    return ADDR_W'(a % (1 << ADDR_W));
  endfunction

  function automatic bit model_slverr(input int len, input int size, input int burst);
    bit wrap_ok;
    wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    return (burst == 3) || (burst == 2 && !wrap_ok) || ((1 << size) > STRB_W);
  endfunction

  // RAM model: each write is acknowledged on its own region after 1..3 cycles.
  initial begin
    logic [NUM_REGION-1:0] s;
    int d;
    forever begin
      @(negedge clk);
      if (ram_en && ram_wr_vld) begin
        s = ram_wr_sel;
        d = $urandom_range(0, 2);
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1 done_sel = s;
        @(posedge clk);
        #1 done_sel = '0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1 noise = NUM_REGION'($urandom);
  end

  initial forever begin
    @(posedge clk);
    #1 BREADY = bready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the oldest prediction whenever the DUT presents an output.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (ram_wr_vld) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write actual=addr 0x%0h required=no write", ram_wr_addr);
        end else begin
          mon_w = wq.pop_front();
          check_output("wr_addr", 64'(ram_wr_addr), 64'(mon_w.addr));
          check_output("wr_data", 64'(ram_wr_data), 64'(mon_w.data));
          check_output("wr_strb", 64'(ram_wr_strb), 64'(mon_w.strb));
          check_output("wr_sel",  64'(ram_wr_sel),  64'(mon_w.sel));
        end
      end
      if (BVALID && BREADY) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_resp actual=id 0x%0h required=no response", BID);
        end else begin
          mon_r = rq.pop_front();
          check_output("bid",   64'(BID),   64'(mon_r.id));
          check_output("bresp", 64'(BRESP), 64'(mon_r.resp));
        end
      end
    end
  end

  task automatic check_reset_values();
    check_output("rst_awready", 64'(AWREADY),     64'd0);
    check_output("rst_wready",  64'(WREADY),      64'd0);
    check_output("rst_bvalid",  64'(BVALID),      64'd0);
    check_output("rst_bresp",   64'(BRESP),       64'd0);
    check_output("rst_bid",     64'(BID),         64'd0);
    check_output("rst_vld",     64'(ram_wr_vld),  64'd0);
    check_output("rst_sel",     64'(ram_wr_sel),  64'd0);
    check_output("rst_addr",    64'(ram_wr_addr), 64'd0);
    check_output("rst_busy",    64'(busy),        64'd0);
  endtask

  // One complete burst: predict, drive AW, drive all beats, then wait for the response.
  task automatic apply_stimulus(input int id, input int addr, input int len,
                                input int size, input int burst, input int region,
                                input int flip, input bit hold_check);
    logic [DATA_W-1:0] dq[$];
    logic [STRB_W-1:0] sq[$];
    wr_t  w;
    rsp_t r;
    bit   writes_on;
    int   n;

    writes_on = (region < NUM_REGION) && !model_slverr(len, size, burst);
    r.id = ID_W'(id);
    if (region >= NUM_REGION)                 r.resp = 2'b11;
    else if (model_slverr(len, size, burst))  r.resp = 2'b10;
`ifdef AXI_WR_WLAST_CHK_EN
    else if (flip >= 0 && flip <= len)        r.resp = 2'b10;
`endif
    else                                      r.resp = 2'b00;
    rq.push_back(r);

    for (int i = 0; i <= len; i++) begin
      dq.push_back(DATA_W'($urandom));
      sq.push_back(STRB_W'($urandom));
      if (writes_on) begin
        w.addr = model_addr(addr, len, size, burst, i);
        w.data = dq[i];
        w.strb = sq[i];
        w.sel  = NUM_REGION'(1) << region;
        wq.push_back(w);
      end
    end
    cur_mask = (region < NUM_REGION) ? (NUM_REGION'(1) << region) : '0;
    if (hold_check) bready_hold = 1'b1;

    step_drive();
    AWID = ID_W'(id); AWADDR = ADDR_W'(addr); AWLEN = 8'(len);
    AWSIZE = 3'(size); AWBURST = 2'(burst); AWREGION = 4'(region);
    AWVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!AWREADY && n < 50);
    if (!AWREADY) begin
      fail_timeout("aw_handshake");
      AWVALID = 1'b0;
      return;
    end
    step_drive();
    AWVALID = 1'b0;

    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, 2)) step_drive();
      // Unrelated address requests while a burst is open must be ignored.
      AWVALID = $urandom_range(0, 1) != 0;
      AWID    = ID_W'($urandom);
      WDATA   = dq[i];
      WSTRB   = sq[i];
      WLAST   = (i == len) ^ (i == flip);
      WVALID  = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!WREADY && n < 50);
      if (!WREADY) begin
        fail_timeout("w_handshake");
        WVALID = 1'b0;
        AWVALID = 1'b0;
        return;
      end
      step_drive();
      WVALID  = 1'b0;
      AWVALID = 1'b0;
    end

    if (hold_check) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!BVALID && n < 50);
      if (!BVALID) fail_timeout("bvalid_wait");
      AWVALID = 1'b1;
      AWID    = ID_W'(id ^ 8'hFF);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check_output("hold_bvalid",  64'(BVALID),  64'd1);
        check_output("hold_bid",     64'(BID),     64'(r.id));
        check_output("hold_bresp",   64'(BRESP),   64'(r.resp));
        check_output("hold_awready", 64'(AWREADY), 64'd0);
      end
      step_drive();
      AWVALID     = 1'b0;
      bready_hold = 1'b0;
    end

    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 300);
    if (busy) fail_timeout("burst_end");
  endtask

  // Reset in the middle of WAIT must abandon the burst without a response.
  task automatic reset_mid_wait();
    int n;
    mon_en   = 1'b0;
    ram_en   = 1'b0;
    cur_mask = 4'b0010;
    step_drive();
    AWID = 8'h77; AWADDR = 11'h100; AWLEN = 8'd3; AWSIZE = 3'd2;
    AWBURST = 2'b01; AWREGION = 4'd1; AWVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!AWREADY && n < 50);
    step_drive();
    AWVALID = 1'b0;
    WDATA = 32'hCAFE_0001; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!WREADY && n < 50);
    step_drive();
    WVALID = 1'b0;
    n = 0;
    while (!ram_wr_vld && n < 10) begin @(negedge clk); n++; end
    check_output("pre_rst_vld", 64'(ram_wr_vld), 64'd1);
    step_drive();
    check_output("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    repeat (2) step_drive();
    check_output("rst_hold_awready", 64'(AWREADY), 64'd0);
    rst_n = 1'b1;
    step_drive();
    check_output("post_rst_awready", 64'(AWREADY), 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_output("post_rst_bvalid", 64'(BVALID), 64'd0);
    end
    ram_en = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int len, size, burst, region, flip;
    int len_tab[6] = '{0, 1, 2, 3, 7, 15};

    rst_n = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWREGION = '0;
    AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;

    repeat (3) step_drive();
    check_reset_values();
    rst_n = 1'b1;
    step_drive();
    check_output("first_awready", 64'(AWREADY), 64'd1);
    check_output("first_busy",    64'(busy),    64'd0);

    $display("[TB] directed bursts");
    apply_stimulus(8'h5A, 11'h000, 3, 2, 1, 1, -1, 1'b0);
    apply_stimulus(8'h11, 11'h008, 3, 2, 2, 1, -1, 1'b0);
    apply_stimulus(8'h12, 11'h008, 3, 2, 0, 2, -1, 1'b0);
    apply_stimulus(8'h21, 11'h100, 1, 2, 1, 5, -1, 1'b0);
    apply_stimulus(8'h22, 11'h010, 2, 2, 2, 0, -1, 1'b0);
    apply_stimulus(8'h23, 11'h000, 1, 3, 1, 0, -1, 1'b0);
    apply_stimulus(8'h24, 11'h000, 1, 2, 3, 6, -1, 1'b0);
    apply_stimulus(8'h30, 11'h7F8, 3, 2, 1, 3, -1, 1'b0);
    apply_stimulus(8'h34, 11'h040, 3, 2, 1, 1,  1, 1'b0);
    apply_stimulus(8'h40, 11'h020, 0, 2, 1, 2, -1, 1'b1);

    $display("[TB] reset during WAIT");
    reset_mid_wait();

    $display("[TB] random bursts");
    for (int b = 0; b < 40; b++) begin
      len    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : len_tab[$urandom_range(0, 5)];
      size   = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      burst  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      region = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      flip   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      apply_stimulus($urandom_range(0, 255), $urandom_range(0, 2047), len, size,
                     burst, region, flip, (b % 10) == 9);
    end

    repeat (5) step_drive();
    check_output("writes_drained",    64'(wq.size()), 64'd0);
    check_output("responses_drained", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
